// File: rtl/uart_test_pkg.sv
// Shared definitions for the UART loopback test: the repeating test pattern,
// the checker state type and the tester ROM lookup.
package uart_test_pkg;

    localparam int PATTERN_LEN = 4;
    localparam logic [7:0] PATTERN [PATTERN_LEN] = '{8'h55, 8'hAA, 8'h00, 8'hFF};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Tester ROM: byte emitted at a given position of the pattern cycle.
    function automatic logic [7:0] tester_rom(input logic [1:0] addr);
        return PATTERN[addr];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; a clear wins over a coincident increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/uart_rx_pattern_checker.sv
// Aligns to the 55/AA/00/FF loopback pattern, verifies the stream once locked
// and reports byte/error counts plus the most recent mismatch.
module uart_rx_pattern_checker
    import uart_test_pkg::*;
#(
    parameter int CNT_WIDTH    = 16,
    parameter int LOCK_MATCHES = 4,
    parameter int LOSS_ERRORS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 clear,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] byte_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 err_pulse,
    output logic [7:0]           last_bad,
    output logic [7:0]           last_exp
);

    localparam int MR_W = $clog2(LOCK_MATCHES + 1);
    localparam int ER_W = $clog2(LOSS_ERRORS + 1);

    chk_state_t      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [MR_W-1:0] match_run_q, match_run_d;
    logic [ER_W-1:0] err_run_q, err_run_d;
    logic            err_pulse_q, err_pulse_d;
    logic [7:0]      last_bad_q, last_bad_d;
    logic [7:0]      last_exp_q, last_exp_d;

    logic            accept;
    logic [7:0]      exp_byte;
    logic [MR_W-1:0] match_inc;
    logic [ER_W-1:0] err_inc;

    assign in_ready  = ~rst;
    assign accept    = in_valid & in_ready;
    assign exp_byte  = tester_rom(idx_q);
    assign match_inc = match_run_q + MR_W'(1);
    assign err_inc   = err_run_q + ER_W'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        match_run_d = match_run_q;
        err_run_d   = err_run_q;
        err_pulse_d = 1'b0;
        last_bad_d  = last_bad_q;
        last_exp_d  = last_exp_q;

        if (accept) begin
            unique case (state_q)
                HUNT: begin
                    if (in_data == PATTERN[0]) begin
                        state_d     = VERIFY;
                        idx_d       = 2'd1;
                        match_run_d = MR_W'(1);
                    end
                end
                VERIFY: begin
                    if (in_data == exp_byte) begin
                        idx_d       = idx_q + 2'd1;
                        match_run_d = match_inc;
                        if (match_inc == MR_W'(LOCK_MATCHES)) begin
                            state_d   = LOCKED;
                            err_run_d = '0;
                        end
                    end else if (in_data == PATTERN[0]) begin
                        // A fresh pattern start mid-verify restarts alignment here.
                        idx_d       = 2'd1;
                        match_run_d = MR_W'(1);
                    end else begin
                        state_d     = HUNT;
                        idx_d       = 2'd0;
                        match_run_d = '0;
                    end
                end
                LOCKED: begin
                    // Mismatches are bit errors: alignment keeps advancing.
                    idx_d = idx_q + 2'd1;
                    if (in_data == exp_byte) begin
                        err_run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        last_bad_d  = in_data;
                        last_exp_d  = exp_byte;
                        err_run_d   = err_inc;
                        if (err_inc == ER_W'(LOSS_ERRORS)) begin
                            state_d     = HUNT;
                            idx_d       = 2'd0;
                            match_run_d = '0;
                            err_run_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    idx_d   = 2'd0;
                end
            endcase
        end

        if (clear) begin
            last_bad_d = 8'h00;
            last_exp_d = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            idx_q       <= 2'd0;
            match_run_q <= '0;
            err_run_q   <= '0;
            err_pulse_q <= 1'b0;
            last_bad_q  <= 8'h00;
            last_exp_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            match_run_q <= match_run_d;
            err_run_q   <= err_run_d;
            err_pulse_q <= err_pulse_d;
            last_bad_q  <= last_bad_d;
            last_exp_q  <= last_exp_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_byte_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (accept),
        .q   (byte_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (err_pulse_d),
        .q   (err_count)
    );

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign last_bad  = last_bad_q;
    assign last_exp  = last_exp_q;

endmodule

// File: tb/tb_uart_rx_pattern_checker.sv
// Bench for uart_rx_pattern_checker: directed vector table plus a randomized
// stream checked against a behavioural model, on a default and a small instance.
module tb_uart_rx_pattern_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       clear = 1'b0;

    logic        a_ready, a_locked, a_pulse;
    logic [15:0] a_bc, a_ec;
    logic [7:0]  a_lb, a_le;
    logic        s_ready, s_locked, s_pulse;
    logic [2:0]  s_bc, s_ec;
    logic [7:0]  s_lb, s_le;

    always #5 clk = ~clk;

    uart_rx_pattern_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready),
        .in_data(in_data), .clear(clear), .locked(a_locked),
        .byte_count(a_bc), .err_count(a_ec), .err_pulse(a_pulse),
        .last_bad(a_lb), .last_exp(a_le)
    );

    uart_rx_pattern_checker #(.CNT_WIDTH(3), .LOCK_MATCHES(2), .LOSS_ERRORS(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ready),
        .in_data(in_data), .clear(clear), .locked(s_locked),
        .byte_count(s_bc), .err_count(s_ec), .err_pulse(s_pulse),
        .last_bad(s_lb), .last_exp(s_le)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: mode 0 = searching, 1 = confirming, 2 = aligned.
    logic [7:0] pat [4] = '{8'h55, 8'hAA, 8'h00, 8'hFF};
    int lock_need [2] = '{4, 2};
    int loss_need [2] = '{2, 1};
    int cnt_max   [2] = '{65535, 7};
    int m_mode [2], m_pos [2], m_good [2], m_miss [2], m_bc [2], m_ec [2];
    int m_lb [2], m_le [2];
    bit m_pulse [2];

    task automatic model_step(input int k, input bit r, input bit v, input logic [7:0] d, input bit c);
        logic [7:0] want;
        if (r) begin
            m_mode[k] = 0; m_pos[k] = 0; m_good[k] = 0; m_miss[k] = 0;
            m_bc[k] = 0; m_ec[k] = 0; m_lb[k] = 0; m_le[k] = 0; m_pulse[k] = 0;
            return;
        end
        m_pulse[k] = 0;
        if (v) begin
            if (m_bc[k] < cnt_max[k]) m_bc[k]++;
            want = pat[m_pos[k]];
            if (m_mode[k] == 0) begin
                if (d == pat[0]) begin m_mode[k] = 1; m_pos[k] = 1; m_good[k] = 1; end
            end else if (m_mode[k] == 1) begin
                if (d == want) begin
                    m_pos[k] = (m_pos[k] + 1) % 4;
                    m_good[k]++;
                    if (m_good[k] >= lock_need[k]) begin m_mode[k] = 2; m_miss[k] = 0; end
                end else if (d == pat[0]) begin
                    m_pos[k] = 1; m_good[k] = 1;
                end else begin
                    m_mode[k] = 0; m_pos[k] = 0; m_good[k] = 0;
                end
            end else begin
                m_pos[k] = (m_pos[k] + 1) % 4;
                if (d == want) m_miss[k] = 0;
                else begin
                    m_pulse[k] = 1;
                    if (m_ec[k] < cnt_max[k]) m_ec[k]++;
                    m_lb[k] = d; m_le[k] = want;
                    m_miss[k]++;
                    if (m_miss[k] >= loss_need[k]) begin
                        m_mode[k] = 0; m_pos[k] = 0; m_good[k] = 0; m_miss[k] = 0;
                    end
                end
            end
        end
        if (c) begin m_bc[k] = 0; m_ec[k] = 0; m_lb[k] = 0; m_le[k] = 0; end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit c);
        rst = r; in_valid = v; in_data = d; clear = c;
        @(posedge clk);
        model_step(0, r, v, d, c);
        model_step(1, r, v, d, c);
        #1;
        check("m_ready",  a_ready,  !r);
        check("m_locked", a_locked, m_mode[0] == 2);
        check("m_pulse",  a_pulse,  m_pulse[0]);
        check("m_bc",     a_bc,     m_bc[0]);
        check("m_ec",     a_ec,     m_ec[0]);
        check("m_lb",     a_lb,     m_lb[0]);
        check("m_le",     a_le,     m_le[0]);
        check("s_ready",  s_ready,  !r);
        check("s_locked", s_locked, m_mode[1] == 2);
        check("s_pulse",  s_pulse,  m_pulse[1]);
        check("s_bc",     s_bc,     m_bc[1]);
        check("s_ec",     s_ec,     m_ec[1]);
        check("s_lb",     s_lb,     m_lb[1]);
        check("s_le",     s_le,     m_le[1]);
    endtask

    typedef struct {
        bit r; bit v; logic [7:0] d; bit c;
        bit el; bit ep;
        bit chk; int bc; int ec; logic [7:0] lb; logic [7:0] le;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit r, bit v, logic [7:0] d, bit c, bit el, bit ep);
        vec_t e;
        e.r = r; e.v = v; e.d = d; e.c = c; e.el = el; e.ep = ep;
        e.chk = 0; e.bc = 0; e.ec = 0; e.lb = 0; e.le = 0;
        tbl.push_back(e);
    endfunction

    function automatic void addc(bit r, bit v, logic [7:0] d, bit c, bit el, bit ep,
                                 int bc, int ec, logic [7:0] lb, logic [7:0] le);
        vec_t e;
        e.r = r; e.v = v; e.d = d; e.c = c; e.el = el; e.ep = ep;
        e.chk = 1; e.bc = bc; e.ec = ec; e.lb = lb; e.le = le;
        tbl.push_back(e);
    endfunction

    initial begin
        int gpos;
        bit r, v, c;
        logic [7:0] d;

        // reset state
        addc(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        add (0, 0, 8'h00, 0, 0, 0);
        // clean stream, lock on 4th byte
        add (0, 1, 8'h55, 0, 0, 0); add(0, 1, 8'hAA, 0, 0, 0);
        add (0, 1, 8'h00, 0, 0, 0); add(0, 1, 8'hFF, 0, 1, 0);
        add (0, 1, 8'h55, 0, 1, 0); add(0, 1, 8'hAA, 0, 1, 0);
        add (0, 1, 8'h00, 0, 1, 0);
        addc(0, 1, 8'hFF, 0, 1, 0, 8, 0, 8'h00, 8'h00);
        // single bit error while locked
        add (0, 1, 8'h55, 0, 1, 0); add(0, 1, 8'hAA, 0, 1, 0);
        add (0, 1, 8'h01, 0, 1, 1); add(0, 1, 8'hFF, 0, 1, 0);
        addc(0, 1, 8'h55, 0, 1, 0, 13, 1, 8'h01, 8'h00);
        add (0, 1, 8'hAA, 0, 1, 0); add(0, 1, 8'h00, 0, 1, 0);
        add (0, 1, 8'hFF, 0, 1, 0);
        addc(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h00);
        // two consecutive mismatches drop lock
        add (0, 1, 8'h55, 0, 1, 0); add(0, 1, 8'h00, 0, 1, 1);
        add (0, 1, 8'hFF, 0, 0, 1); add(0, 1, 8'h55, 0, 0, 0);
        addc(0, 1, 8'hAA, 0, 0, 0, 5, 2, 8'hFF, 8'h00);
        // hunt skips leading garbage
        addc(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        add (0, 0, 8'h00, 0, 0, 0);
        add (0, 1, 8'h12, 0, 0, 0); add(0, 1, 8'h34, 0, 0, 0);
        add (0, 1, 8'h55, 0, 0, 0); add(0, 1, 8'hAA, 0, 0, 0);
        add (0, 1, 8'h00, 0, 0, 0);
        addc(0, 1, 8'hFF, 0, 1, 0, 6, 0, 8'h00, 8'h00);
        // restart on a second 55 during verify
        add (1, 0, 8'h00, 0, 0, 0); add(0, 0, 8'h00, 0, 0, 0);
        add (0, 1, 8'h55, 0, 0, 0); add(0, 1, 8'hAA, 0, 0, 0);
        add (0, 1, 8'h55, 0, 0, 0); add(0, 1, 8'hAA, 0, 0, 0);
        add (0, 1, 8'h00, 0, 0, 0);
        addc(0, 1, 8'hFF, 0, 1, 0, 6, 0, 8'h00, 8'h00);
        // clear together with a counted mismatch
        addc(0, 1, 8'hAA, 1, 1, 1, 0, 0, 8'h00, 8'h00);
        addc(0, 1, 8'hAA, 0, 1, 0, 1, 0, 8'h00, 8'h00);
        addc(0, 1, 8'h55, 0, 1, 1, 2, 1, 8'h55, 8'h00);
        // reset mid-stream while a byte is offered
        addc(1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        add (0, 0, 8'h00, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
            check($sformatf("row%0d_locked", i), a_locked, tbl[i].el);
            check($sformatf("row%0d_pulse", i),  a_pulse,  tbl[i].ep);
            check($sformatf("row%0d_ready", i),  a_ready,  !tbl[i].r);
            if (tbl[i].chk) begin
                check($sformatf("row%0d_bc", i), a_bc, tbl[i].bc);
                check($sformatf("row%0d_ec", i), a_ec, tbl[i].ec);
                check($sformatf("row%0d_lb", i), a_lb, tbl[i].lb);
                check($sformatf("row%0d_le", i), a_le, tbl[i].le);
            end
        end

        // randomized stream, mostly on-pattern with injected errors
        gpos = 0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(999) < 3);
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(99) == 0);
            if ($urandom_range(9) < 8) begin
                d = pat[gpos];
            end else begin
                d = 8'($urandom);
            end
            if (v) gpos = (gpos + 1) % 4;
            if ($urandom_range(49) == 0) gpos = $urandom_range(3);
            step(r, v, d, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
